// File: rtl/switch_emu_pkg.sv
// Shared types and constants for the switch bounce emulator and its LFSR.
package switch_emu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        DONE   = 2'd2
    } emu_state_t;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances only when enabled; an all-zero seed is remapped to 1.
module lfsr16
    import switch_emu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic [15:0] seed_safe;

    // The all-zero state is a lock-up state for this LFSR.
    assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = lfsr_step(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q <= seed_safe;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/switch_bounce_emulator.sv
// Drives a single-bit line like a mechanical switch: on each accepted request it emits a
// programmable burst of bounce cycles, then settles to a clean level and pulses o_done.
module switch_bounce_emulator
    import switch_emu_pkg::*;
#(
    parameter int          N_BOUNCE  = 4,
    parameter bit          IS_PULLUP = 1'b1,
    parameter int          PATTERN   = 0,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_level,
    input  logic                i_settle,
    input  logic [N_BOUNCE-1:0] i_bounce_len,
    output logic                o_sig,
    output logic                o_busy,
    output logic                o_done
);

    emu_state_t          state_q, state_d;
    logic [N_BOUNCE-1:0] cnt_q, cnt_d;
    logic                target_q, target_d;
    logic                o_sig_q, o_sig_d;
    logic                o_ready_q, o_ready_d;
    logic                o_busy_q, o_busy_d;
    logic                o_done_q, o_done_d;
    logic                lfsr_en;
    logic [15:0]         lfsr_q;
    logic                accept;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .en   (lfsr_en),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    // A request needs both the FSM in IDLE and the registered ready flag, which lags by a cycle.
    assign accept = i_valid && o_ready_q && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        o_sig_d   = o_sig_q;
        o_ready_d = (state_q == IDLE);
        o_busy_d  = (state_q != IDLE);
        o_done_d  = 1'b0;
        lfsr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // The starting level is o_sig itself, so toggling begins at its complement.
                    target_d = i_settle ? i_level : o_sig_q;
                    cnt_d    = i_bounce_len;
                    state_d  = (i_bounce_len == '0) ? DONE : BOUNCE;
                end
            end
            BOUNCE: begin
                cnt_d = cnt_q - N_BOUNCE'(1);
                if (PATTERN == 1) begin
                    o_sig_d = lfsr_q[0];
                    lfsr_en = 1'b1;
                end else begin
                    o_sig_d = ~o_sig_q;
                end
                if (cnt_q == N_BOUNCE'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_sig_d  = target_q;
                o_done_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            target_q  <= IS_PULLUP;
            o_sig_q   <= IS_PULLUP;
            o_ready_q <= 1'b1;
            o_busy_q  <= 1'b0;
            o_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            o_sig_q   <= o_sig_d;
            o_ready_q <= o_ready_d;
            o_busy_q  <= o_busy_d;
            o_done_q  <= o_done_d;
        end
    end

    assign o_sig   = o_sig_q;
    assign o_ready = o_ready_q;
    assign o_busy  = o_busy_q;
    assign o_done  = o_done_q;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Directed bench for switch_bounce_emulator: toggle-pattern and LFSR-pattern instances share stimulus.
module tb_switch_bounce_emulator;

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_valid;
    logic       i_level;
    logic       i_settle;
    logic [3:0] i_bounce_len;

    logic sig0, ready0, busy0, done0;
    logic sig1, ready1, busy1, done1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    switch_bounce_emulator #(
        .N_BOUNCE (4), .IS_PULLUP (1'b1), .PATTERN (0), .LFSR_SEED (16'hACE1)
    ) u_dut0 (
        .clk (clk), .rstn (rstn), .i_valid (i_valid), .o_ready (ready0),
        .i_level (i_level), .i_settle (i_settle), .i_bounce_len (i_bounce_len),
        .o_sig (sig0), .o_busy (busy0), .o_done (done0)
    );

    switch_bounce_emulator #(
        .N_BOUNCE (4), .IS_PULLUP (1'b1), .PATTERN (1), .LFSR_SEED (16'hACE1)
    ) u_dut1 (
        .clk (clk), .rstn (rstn), .i_valid (i_valid), .o_ready (ready1),
        .i_level (i_level), .i_settle (i_settle), .i_bounce_len (i_bounce_len),
        .o_sig (sig1), .o_busy (busy1), .o_done (done1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // Presents a one-cycle request; returns just after the accepting edge k.
    task automatic request(input logic lvl, input logic settle, input logic [3:0] len);
        i_valid      = 1'b1;
        i_level      = lvl;
        i_settle     = settle;
        i_bounce_len = len;
        tick;
        i_valid = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    initial begin
        logic [15:0] m;

        rstn = 1'b0; i_valid = 1'b0; i_level = 1'b0; i_settle = 1'b0; i_bounce_len = 4'd0;
        for (int i = 0; i < 10; i++) tick;
        chk("rst_sig",   sig0,   1'b1);
        chk("rst_ready", ready0, 1'b1);
        chk("rst_busy",  busy0,  1'b0);
        chk("rst_done",  done0,  1'b0);
        chk("rst_sig1",  sig1,   1'b1);
        rstn = 1'b1;
        tick;

        // Clean falling edge
        request(1'b0, 1'b1, 4'd0);
        chk("clean_k_sig",   sig0,   1'b1);
        chk("clean_k_ready", ready0, 1'b1);
        chk("clean_k_done",  done0,  1'b0);
        tick;
        chk("clean_k1_sig",   sig0,   1'b0);
        chk("clean_k1_done",  done0,  1'b1);
        chk("clean_k1_ready", ready0, 1'b0);
        chk("clean_k1_busy",  busy0,  1'b1);
        tick;
        chk("clean_k2_ready", ready0, 1'b1);
        chk("clean_k2_done",  done0,  1'b0);
        chk("clean_k2_busy",  busy0,  1'b0);
        chk("clean_k2_sig",   sig0,   1'b0);

        // Clean rise back to 1
        request(1'b1, 1'b1, 4'd0);
        tick;
        chk("rise_sig", sig0, 1'b1);
        tick;

        // Toggle burst, length 10, settle at 0
        request(1'b0, 1'b1, 4'd10);
        for (int i = 1; i <= 10; i++) begin
            tick;
            chk($sformatf("toggle_sig[%0d]", i),  sig0,  (i % 2 == 0));
            chk($sformatf("toggle_done[%0d]", i), done0, 1'b0);
        end
        tick;
        chk("toggle_end_sig",  sig0,  1'b0);
        chk("toggle_end_done", done0, 1'b1);
        tick;
        chk("toggle_end_ready", ready0, 1'b1);
        chk("toggle_end_done2", done0,  1'b0);

        // Back to 1, then aborted press of length 5
        request(1'b1, 1'b1, 4'd0);
        tick;
        tick;
        request(1'b0, 1'b0, 4'd5);
        for (int i = 1; i <= 5; i++) begin
            tick;
            chk($sformatf("abort_sig[%0d]", i), sig0, (i % 2 == 0));
        end
        tick;
        chk("abort_end_sig",  sig0,  1'b1);
        chk("abort_end_done", done0, 1'b1);
        tick;
        chk("abort_end_ready", ready0, 1'b1);

        // Busy rejection with a request held high throughout
        i_valid = 1'b1; i_level = 1'b0; i_settle = 1'b1; i_bounce_len = 4'd3;
        tick;
        tick;
        chk("hold_b1_sig",  sig0,  1'b0);
        chk("hold_b1_done", done0, 1'b0);
        tick;
        chk("hold_b2_sig",  sig0,  1'b1);
        chk("hold_b2_done", done0, 1'b0);
        tick;
        chk("hold_b3_sig",  sig0,  1'b0);
        chk("hold_b3_done", done0, 1'b0);
        tick;
        chk("hold_d_sig",  sig0,  1'b0);
        chk("hold_d_done", done0, 1'b1);
        tick;
        chk("hold_idle_ready", ready0, 1'b1);
        chk("hold_idle_busy",  busy0,  1'b0);
        chk("hold_idle_done",  done0,  1'b0);
        tick;
        i_valid = 1'b0;
        chk("hold_acc_ready", ready0, 1'b1);
        chk("hold_acc_sig",   sig0,   1'b0);
        tick;
        chk("hold2_b1_sig",   sig0,   1'b1);
        chk("hold2_b1_ready", ready0, 1'b0);
        tick;
        chk("hold2_b2_sig", sig0, 1'b0);
        tick;
        chk("hold2_b3_sig", sig0, 1'b1);
        tick;
        chk("hold2_d_sig",  sig0,  1'b0);
        chk("hold2_d_done", done0, 1'b1);
        tick;
        chk("hold2_ready", ready0, 1'b1);

        // LFSR pattern with reset in the middle of the burst
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        chk("lfsr_pre_sig1", sig1, 1'b1);
        request(1'b0, 1'b1, 4'd15);
        m = 16'hACE1;
        for (int i = 1; i <= 7; i++) begin
            tick;
            chk($sformatf("lfsr_a_sig[%0d]", i), sig1, m[0]);
            m = lfsr_next(m);
        end
        rstn = 1'b0;
        tick;
        chk("midrst_sig1",   sig1,   1'b1);
        chk("midrst_sig0",   sig0,   1'b1);
        chk("midrst_ready1", ready1, 1'b1);
        chk("midrst_busy1",  busy1,  1'b0);
        chk("midrst_done1",  done1,  1'b0);
        rstn = 1'b1;
        tick;
        chk("postrst_done1",  done1,  1'b0);
        chk("postrst_ready1", ready1, 1'b1);
        chk("postrst_sig1",   sig1,   1'b1);
        request(1'b0, 1'b1, 4'd15);
        m = 16'hACE1;
        for (int i = 1; i <= 15; i++) begin
            tick;
            chk($sformatf("lfsr_b_sig[%0d]", i),  sig1,  m[0]);
            chk($sformatf("lfsr_b_done[%0d]", i), done1, 1'b0);
            m = lfsr_next(m);
        end
        tick;
        chk("lfsr_end_sig1",  sig1,  1'b0);
        chk("lfsr_end_done1", done1, 1'b1);
        tick;
        chk("lfsr_end_ready1", ready1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
